// File: rtl/memory_access_if.sv
// EX/MEM -> MEM stage bundle: instruction fields in, branch resolution,
// stall and MEM/WB register contents out.
interface memory_access_if;
  logic        valid_in;
  logic [1:0]  wb_ctl;
  logic        branch;
  logic        memread;
  logic        memwrite;
  logic        zero;
  logic [31:0] add_result;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic [4:0]  five_bit_muxout;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        stall;
  logic [1:0]  wb_ctlout;
  logic [31:0] read_data;
  logic [31:0] alu_result_out;
  logic [4:0]  dest_reg;
  logic        valid_out;

  modport master (
    output valid_in, wb_ctl, branch, memread, memwrite, zero,
           add_result, alu_result, rdata2out, five_bit_muxout,
    input  pcsrc, branch_target, stall, wb_ctlout, read_data,
           alu_result_out, dest_reg, valid_out
  );

  modport slave (
    input  valid_in, wb_ctl, branch, memread, memwrite, zero,
           add_result, alu_result, rdata2out, five_bit_muxout,
    output pcsrc, branch_target, stall, wb_ctlout, read_data,
           alu_result_out, dest_reg, valid_out
  );
endinterface

// File: rtl/memory_access.sv
// MEM pipeline stage: word-addressed data memory with configurable latency,
// branch resolution, upstream stall generation and the MEM/WB register.
module memory_access #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input logic           clk,
  input logic           rst_n,
  memory_access_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t            state;
  logic [2:0]        cnt;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              memop;
  logic              stall_c;
  logic              complete;

  assign idx      = bus.alu_result[ADDR_W+1:2];
  assign memop    = bus.valid_in & (bus.memread | bus.memwrite);
  assign complete = ~stall_c;

  assign bus.pcsrc         = bus.valid_in & bus.branch & bus.zero;
  assign bus.branch_target = bus.add_result;
  assign bus.stall         = stall_c;

  always_comb begin
    stall_c = 1'b0;
    case (state)
      IDLE:    stall_c = memop && (LAT != 3'd0);
      BUSY:    stall_c = (cnt > 3'd1);
      default: stall_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (memop && (LAT != 3'd0)) begin
            state <= BUSY;
            cnt   <= LAT;
          end
        end
        BUSY: begin
          if (cnt > 3'd1) begin
            cnt <= cnt - 3'd1;
          end else begin
            state <= IDLE;
            cnt   <= 3'd0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // ---- MEM/WB register: real entry on completion, bubble while stalled ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_out      <= 1'b0;
      bus.wb_ctlout      <= 2'b00;
      bus.read_data      <= 32'd0;
      bus.alu_result_out <= 32'd0;
      bus.dest_reg       <= 5'd0;
    end else if (complete) begin
      bus.valid_out      <= bus.valid_in;
      bus.wb_ctlout      <= bus.valid_in ? bus.wb_ctl : 2'b00;
      bus.read_data      <= (bus.valid_in && bus.memread) ? mem[idx] : 32'd0;
      bus.alu_result_out <= bus.alu_result;
      bus.dest_reg       <= bus.five_bit_muxout;
    end else begin
      bus.valid_out <= 1'b0;
      bus.wb_ctlout <= 2'b00;
    end
  end

  // Memory contents survive reset; a store held across reset never commits.
  always_ff @(posedge clk) begin
    if (rst_n && complete && bus.valid_in && bus.memwrite)
      mem[idx] <= bus.rdata2out;
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MEM stage (ADDR_W=8, MEM_LAT=2).
module tb_memory_access;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  memory_access_if bus ();

  memory_access #(.ADDR_W(8), .MEM_LAT(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  wb;
    logic        br;
    logic        rd;
    logic        wr;
    logic        z;
    logic [31:0] add;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  dst;
    logic        e_pc;
    int          e_st;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tv[14];

  function automatic vec_t mk(logic v, logic [1:0] wb, logic br, logic rd, logic wr,
                              logic z, logic [31:0] add, logic [31:0] alu,
                              logic [31:0] wd, logic [4:0] dst, logic e_pc,
                              int e_st, logic [31:0] e_rd);
    vec_t t;
    t.v = v; t.wb = wb; t.br = br; t.rd = rd; t.wr = wr; t.z = z;
    t.add = add; t.alu = alu; t.wd = wd; t.dst = dst;
    t.e_pc = e_pc; t.e_st = e_st; t.e_rd = e_rd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.valid_in        = t.v;
    bus.wb_ctl          = t.wb;
    bus.branch          = t.br;
    bus.memread         = t.rd;
    bus.memwrite        = t.wr;
    bus.zero            = t.z;
    bus.add_result      = t.add;
    bus.alu_result      = t.alu;
    bus.rdata2out       = t.wd;
    bus.five_bit_muxout = t.dst;
  endtask

  task automatic apply(input vec_t t);
    int st;
    @(negedge clk);
    drive(t);
    #1;
    chk("pcsrc", 32'(bus.pcsrc), 32'(t.e_pc));
    chk("branch_target", bus.branch_target, t.add);
    st = 0;
    while (bus.stall && st < 20) begin
      @(posedge clk);
      #1;
      chk("stall_bubble_valid", 32'(bus.valid_out), 32'd0);
      chk("stall_bubble_wb", 32'(bus.wb_ctlout), 32'd0);
      st++;
    end
    chk("stall_cycles", 32'(st), 32'(t.e_st));
    @(posedge clk);
    #1;
    chk("valid_out", 32'(bus.valid_out), 32'(t.v));
    chk("wb_ctlout", 32'(bus.wb_ctlout), t.v ? 32'(t.wb) : 32'd0);
    chk("read_data", bus.read_data, t.e_rd);
    chk("alu_result_out", bus.alu_result_out, t.alu);
    chk("dest_reg", 32'(bus.dest_reg), 32'(t.dst));
  endtask

  vec_t idle_v;

  initial begin
    //          v  wb     br rd wr z  add         alu         wd          dst  pc st rd
    tv[0]  = mk(1, 2'b10, 0, 0, 0, 0, 32'h0,      32'h7,      32'h0,      5,   0, 0, 32'h0);
    tv[1]  = mk(1, 2'b00, 0, 0, 1, 0, 32'h0,      32'h10,     32'hDEADBEEF, 0, 0, 2, 32'h0);
    tv[2]  = mk(1, 2'b11, 0, 1, 0, 0, 32'h0,      32'h10,     32'h0,      3,   0, 2, 32'hDEADBEEF);
    tv[3]  = mk(1, 2'b00, 1, 0, 0, 1, 32'h40,     32'h0,      32'h0,      0,   1, 0, 32'h0);
    tv[4]  = mk(1, 2'b00, 1, 0, 0, 0, 32'h40,     32'h1,      32'h0,      0,   0, 0, 32'h0);
    tv[5]  = mk(0, 2'b10, 1, 0, 0, 1, 32'h40,     32'h2,      32'h0,      4,   0, 0, 32'h0);
    tv[6]  = mk(1, 2'b00, 0, 0, 1, 0, 32'h0,      32'h400,    32'h1,      0,   0, 2, 32'h0);
    tv[7]  = mk(1, 2'b11, 0, 1, 0, 0, 32'h0,      32'h0,      32'h0,      7,   0, 2, 32'h1);
    tv[8]  = mk(1, 2'b11, 0, 1, 0, 0, 32'h0,      32'h3,      32'h0,      8,   0, 2, 32'h1);
    tv[9]  = mk(0, 2'b11, 0, 0, 1, 0, 32'h0,      32'h0,      32'hFF,     9,   0, 0, 32'h0);
    tv[10] = mk(1, 2'b11, 0, 1, 0, 0, 32'h0,      32'h0,      32'h0,      10,  0, 2, 32'h1);
    tv[11] = mk(1, 2'b00, 0, 0, 1, 0, 32'h0,      32'h20,     32'hA,      0,   0, 2, 32'h0);
    tv[12] = mk(1, 2'b11, 0, 1, 1, 0, 32'h0,      32'h20,     32'hB,      12,  0, 2, 32'hA);
    tv[13] = mk(1, 2'b11, 0, 1, 0, 0, 32'h0,      32'h20,     32'h0,      13,  0, 2, 32'hB);
    idle_v = mk(0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);

    // Reset state
    drive(idle_v);
    #1;
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_wb_ctlout", 32'(bus.wb_ctlout), 32'd0);
    chk("rst_read_data", bus.read_data, 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) apply(tv[i]);

    // Reset in the middle of a stalled store to a word holding 0xDEADBEEF
    @(negedge clk);
    drive(mk(1, 2'b00, 0, 0, 1, 0, 32'h0, 32'h10, 32'h55, 6, 0, 0, 32'h0));
    @(posedge clk);
    #1;
    chk("busy_stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("midrst_wb_ctlout", 32'(bus.wb_ctlout), 32'd0);
    chk("midrst_read_data", bus.read_data, 32'd0);
    chk("midrst_alu_out", bus.alu_result_out, 32'd0);
    chk("midrst_dest_reg", 32'(bus.dest_reg), 32'd0);
    drive(idle_v);
    #1;
    chk("midrst_stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 2'b11, 0, 1, 0, 0, 32'h0, 32'h10, 32'h0, 11, 0, 2, 32'hDEADBEEF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
